// File: rtl/k423_imem_rsp.sv
// Instruction-memory responder: word-organised synchronous memory behind the
// fetch interface, with a fixed response latency and an outstanding-request cap.
module k423_imem_rsp #(
  parameter int    ADDR_W          = 32,
  parameter int    DATA_W          = 32,
  parameter int    DEPTH           = 1024,
  parameter int    LATENCY         = 1,
  parameter int    MAX_OUTSTANDING = 1,
  parameter string INIT_FILE       = ""
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              mem_req_vld_i,
  input  logic              mem_req_wen_i,
  input  logic [ADDR_W-1:0] mem_req_addr_i,
  input  logic [DATA_W-1:0] mem_req_wdata_i,
  output logic              mem_req_rdy_o,
  output logic              mem_rsp_vld_o,
  output logic [DATA_W-1:0] mem_rsp_rdata_o,
  input  logic              stall_i
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [DATA_W-1:0]              mem_q [DEPTH];
  logic [IDX_W-1:0]               word_idx;
  logic                           accept;
  logic [LATENCY-1:0]             pipe_vld_q, pipe_vld_d;
  logic [LATENCY-1:0][DATA_W-1:0] pipe_data_q, pipe_data_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           unused_addr;

  // Request handshake: a request transfers on a rising edge where vld and rdy
  // are both high. rdy never looks at vld; a response leaving the pipe this
  // cycle frees its slot for a same-cycle accept. Responses have no ready.
  assign mem_req_rdy_o = ~stall_i &
                         ((cnt_q < CNT_W'(MAX_OUTSTANDING)) | pipe_vld_q[LATENCY-1]);
  assign accept        = mem_req_vld_i & mem_req_rdy_o;

  // Low two bits and bits above the array size are ignored: aligned down, wrapped.
  assign word_idx    = mem_req_addr_i[IDX_W+1:2];
  assign unused_addr = ^mem_req_addr_i;

  assign mem_rsp_vld_o   = pipe_vld_q[LATENCY-1];
  assign mem_rsp_rdata_o = pipe_data_q[LATENCY-1];

  always_ff @(posedge clk_i) begin
    if (accept && mem_req_wen_i) begin
      mem_q[word_idx] <= mem_req_wdata_i;
    end
  end

  // Data stages only load when a valid enters them, so the output word holds
  // between responses.
  always_comb begin
    pipe_vld_d     = '0;
    pipe_data_d    = pipe_data_q;
    pipe_vld_d[0]  = accept;
    if (accept) begin
      pipe_data_d[0] = mem_req_wen_i ? '0 : mem_q[word_idx];
    end
    for (int i = 1; i < LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      if (pipe_vld_q[i-1]) begin
        pipe_data_d[i] = pipe_data_q[i-1];
      end
    end
    cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(pipe_vld_q[LATENCY-1]);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pipe_vld_q  <= '0;
      pipe_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      pipe_vld_q  <= pipe_vld_d;
      pipe_data_q <= pipe_data_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_k423_imem_rsp.sv
// Directed bench for k423_imem_rsp: four instances with different latency and
// outstanding caps, driven and checked cycle by cycle against hand-derived values.
module tb_k423_imem_rsp;

  localparam int N = 4;
  localparam int LAT_P [N] = '{1, 3, 2, 3};
  localparam int MAX_P [N] = '{1, 1, 2, 3};

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]       vld, wen, stall, rdy, rvld;
  logic [N-1:0][31:0] addr, wdata, rdata;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    k423_imem_rsp #(
      .ADDR_W(32), .DATA_W(32), .DEPTH(1024),
      .LATENCY(LAT_P[g]), .MAX_OUTSTANDING(MAX_P[g]), .INIT_FILE("")
    ) u_dut (
      .clk_i(clk),
      .rst_n_i(rst_n),
      .mem_req_vld_i(vld[g]),
      .mem_req_wen_i(wen[g]),
      .mem_req_addr_i(addr[g]),
      .mem_req_wdata_i(wdata[g]),
      .mem_req_rdy_o(rdy[g]),
      .mem_rsp_vld_o(rvld[g]),
      .mem_rsp_rdata_o(rdata[g]),
      .stall_i(stall[g])
    );
  end

  task automatic set_req(input int idx, input logic v, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    vld[idx]   = v;
    wen[idx]   = w;
    addr[idx]  = a;
    wdata[idx] = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Write one word and let its response drain; bounded wait on rdy.
  task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    set_req(idx, 1'b1, 1'b1, a, d);
    #1;
    while (!rdy[idx] && n < 20) begin
      next_cycle();
      #1;
      n++;
    end
    checks++;
    if (!rdy[idx]) begin
      errors++;
      $display("FAIL load_rdy_timeout inst%0d: rdy %b, required 1", idx, rdy[idx]);
    end
    next_cycle();
    set_req(idx, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (6) next_cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vld = '0; wen = '0; stall = '0; addr = '0; wdata = '0;
    repeat (2) next_cycle();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (rvld[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_rsp_vld inst%0d: got %b, required 0", i, rvld[i]);
      end
      checks++;
      if (rdata[i] !== 32'h0) begin
        errors++;
        $display("FAIL reset_rdata inst%0d: got %h, required 0", i, rdata[i]);
      end
      checks++;
      if (rdy[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset_rdy inst%0d: got %b, required 1", i, rdy[i]);
      end
    end
    rst_n = 1'b1;
    next_cycle();
  endtask

  // LATENCY=1: load two instructions by write, then fetch them back to back.
  task automatic test_fetch();
    logic        v_t [6] = '{1, 1, 1, 1, 0, 0};
    logic        w_t [6] = '{1, 1, 0, 0, 0, 0};
    logic [31:0] a_t [6] = '{32'h0, 32'h4, 32'h0, 32'h4, 32'h0, 32'h0};
    logic [31:0] d_t [6] = '{32'h13, 32'h00100093, 32'h0, 32'h0, 32'h0, 32'h0};
    logic        e_v [6] = '{0, 1, 1, 1, 1, 0};
    logic [31:0] e_d [6] = '{32'h0, 32'h0, 32'h0, 32'h13, 32'h00100093, 32'h0};
    for (int c = 0; c < 6; c++) begin
      set_req(0, v_t[c], w_t[c], a_t[c], d_t[c]);
      #1;
      checks++;
      if (rdy[0] !== 1'b1) begin
        errors++;
        $display("FAIL fetch_rdy c%0d: got %b, required 1", c, rdy[0]);
      end
      checks++;
      if (rvld[0] !== e_v[c]) begin
        errors++;
        $display("FAIL fetch_rsp_vld c%0d: got %b, required %b", c, rvld[0], e_v[c]);
      end
      if (e_v[c]) begin
        checks++;
        if (rdata[0] !== e_d[c]) begin
          errors++;
          $display("FAIL fetch_rdata c%0d: got %h, required %h", c, rdata[0], e_d[c]);
        end
      end
      next_cycle();
    end
  endtask

  // LATENCY=2, cap 2: write then read-after-write, misaligned alias of same word.
  task automatic test_raw();
    logic        v_t [6] = '{1, 1, 1, 0, 0, 0};
    logic        w_t [6] = '{1, 0, 0, 0, 0, 0};
    logic [31:0] a_t [6] = '{32'h10, 32'h10, 32'h13, 32'h0, 32'h0, 32'h0};
    logic [31:0] d_t [6] = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic        e_v [6] = '{0, 0, 1, 1, 1, 0};
    logic [31:0] e_d [6] = '{32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    for (int c = 0; c < 6; c++) begin
      set_req(2, v_t[c], w_t[c], a_t[c], d_t[c]);
      #1;
      checks++;
      if (rdy[2] !== 1'b1) begin
        errors++;
        $display("FAIL raw_rdy c%0d: got %b, required 1", c, rdy[2]);
      end
      checks++;
      if (rvld[2] !== e_v[c]) begin
        errors++;
        $display("FAIL raw_rsp_vld c%0d: got %b, required %b", c, rvld[2], e_v[c]);
      end
      if (e_v[c]) begin
        checks++;
        if (rdata[2] !== e_d[c]) begin
          errors++;
          $display("FAIL raw_rdata c%0d: got %h, required %h", c, rdata[2], e_d[c]);
        end
      end
      next_cycle();
    end
  endtask

  // Out-of-range address wraps onto word 1; word 0 must stay intact.
  task automatic test_wrap();
    logic        v_t [6] = '{1, 1, 1, 1, 0, 0};
    logic        w_t [6] = '{1, 0, 0, 0, 0, 0};
    logic [31:0] a_t [6] = '{32'h00001004, 32'h4, 32'h7, 32'h0, 32'h0, 32'h0};
    logic [31:0] d_t [6] = '{32'hA5A5A5A5, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic        e_v [6] = '{0, 1, 1, 1, 1, 0};
    logic [31:0] e_d [6] = '{32'h0, 32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h13, 32'h0};
    for (int c = 0; c < 6; c++) begin
      set_req(0, v_t[c], w_t[c], a_t[c], d_t[c]);
      #1;
      checks++;
      if (rvld[0] !== e_v[c]) begin
        errors++;
        $display("FAIL wrap_rsp_vld c%0d: got %b, required %b", c, rvld[0], e_v[c]);
      end
      if (e_v[c]) begin
        checks++;
        if (rdata[0] !== e_d[c]) begin
          errors++;
          $display("FAIL wrap_rdata c%0d: got %h, required %h", c, rdata[0], e_d[c]);
        end
      end
      next_cycle();
    end
  endtask

  // LATENCY=3, cap 1: three reads offered continuously.
  task automatic test_back_to_back();
    logic        e_r [11] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1};
    logic        e_v [11] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
    logic [31:0] e_d [3]  = '{32'h11110000, 32'h22220000, 32'h33330000};
    int n_acc;
    int n_rsp;
    n_acc = 0;
    n_rsp = 0;
    for (int c = 0; c < 11; c++) begin
      set_req(1, n_acc < 3, 1'b0, 32'h20 + 32'(4 * n_acc), 32'h0);
      #1;
      checks++;
      if (rdy[1] !== e_r[c]) begin
        errors++;
        $display("FAIL b2b_rdy c%0d: got %b, required %b", c, rdy[1], e_r[c]);
      end
      checks++;
      if (rvld[1] !== e_v[c]) begin
        errors++;
        $display("FAIL b2b_rsp_vld c%0d: got %b, required %b", c, rvld[1], e_v[c]);
      end
      if (e_v[c] && n_rsp < 3) begin
        checks++;
        if (rdata[1] !== e_d[n_rsp]) begin
          errors++;
          $display("FAIL b2b_rdata c%0d: got %h, required %h", c, rdata[1], e_d[n_rsp]);
        end
        n_rsp++;
      end
      if (vld[1] && rdy[1]) n_acc++;
      next_cycle();
    end
    checks++;
    if (n_acc != 3) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d, required 3", n_acc);
    end
  endtask

  // stall_i blocks new accepts but not the in-flight response.
  task automatic test_stall();
    logic e_r;
    logic e_v;
    for (int c = 0; c < 10; c++) begin
      stall[1] = (c >= 1 && c <= 5);
      set_req(1, c <= 6, 1'b0, (c == 0) ? 32'h20 : 32'h24, 32'h0);
      #1;
      e_r = (c == 0 || c == 6);
      e_v = (c == 3 || c == 9);
      if (c <= 6) begin
        checks++;
        if (rdy[1] !== e_r) begin
          errors++;
          $display("FAIL stall_rdy c%0d: got %b, required %b", c, rdy[1], e_r);
        end
      end
      checks++;
      if (rvld[1] !== e_v) begin
        errors++;
        $display("FAIL stall_rsp_vld c%0d: got %b, required %b", c, rvld[1], e_v);
      end
      if (e_v) begin
        checks++;
        if (rdata[1] !== ((c == 3) ? 32'h11110000 : 32'h22220000)) begin
          errors++;
          $display("FAIL stall_rdata c%0d: got %h, required %h", c, rdata[1],
                   (c == 3) ? 32'h11110000 : 32'h22220000);
        end
      end
      next_cycle();
    end
    stall[1] = 1'b0;
  endtask

  // LATENCY=3, cap 3: reset with responses in flight, then re-read memory.
  task automatic test_reset_inflight();
    for (int c = 0; c < 3; c++) begin
      set_req(3, 1'b1, 1'b0, 32'h40, 32'h0);
      #1;
      checks++;
      if (rdy[3] !== 1'b1) begin
        errors++;
        $display("FAIL rst_fill_rdy c%0d: got %b, required 1", c, rdy[3]);
      end
      next_cycle();
    end
    set_req(3, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checks++;
    if (rvld[3] !== 1'b1 || rdata[3] !== 32'hC0FFEE00) begin
      errors++;
      $display("FAIL rst_first_rsp: got vld %b data %h, required vld 1 data c0ffee00",
               rvld[3], rdata[3]);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rvld[3] !== 1'b0) begin
      errors++;
      $display("FAIL rst_async_vld: got %b, required 0", rvld[3]);
    end
    checks++;
    if (rdata[3] !== 32'h0) begin
      errors++;
      $display("FAIL rst_async_rdata: got %h, required 0", rdata[3]);
    end
    @(posedge clk);
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (rvld[3] !== 1'b0) begin
        errors++;
        $display("FAIL rst_stale_rsp c%0d: got %b, required 0", c, rvld[3]);
      end
      next_cycle();
    end
    for (int c = 0; c < 4; c++) begin
      set_req(3, c == 0, 1'b0, 32'h40, 32'h0);
      #1;
      checks++;
      if (rvld[3] !== (c == 3)) begin
        errors++;
        $display("FAIL rst_reread_vld c%0d: got %b, required %b", c, rvld[3], c == 3);
      end
      if (c == 3) begin
        checks++;
        if (rdata[3] !== 32'hC0FFEE00) begin
          errors++;
          $display("FAIL rst_reread_rdata: got %h, required c0ffee00", rdata[3]);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_raw();
    test_wrap();
    load(1, 32'h20, 32'h11110000);
    load(1, 32'h24, 32'h22220000);
    load(1, 32'h28, 32'h33330000);
    test_back_to_back();
    test_stall();
    load(3, 32'h40, 32'hC0FFEE00);
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
